// File: rtl/pipeline_run_monitor.sv
// rtl/pipeline_run_monitor.sv - run-completion monitor with drain, watchdog and counters
module pipeline_run_monitor #(
  parameter int NUM_CORES      = 1,
  parameter int DRAIN_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic [NUM_CORES-1:0] program_done,
  input  logic [NUM_CORES-1:0] done_mask,
  input  logic [NUM_CORES-1:0] retire_valid,
  output logic                 terminate,
  output logic                 timed_out,
  output logic                 running,
  output logic [NUM_CORES-1:0] done_flags,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retire_count
);

  localparam int PW = $clog2(NUM_CORES + 1);
  localparam int SW = CNT_WIDTH + PW;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam bit WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam bit NO_DRAIN  = (DRAIN_CYCLES == 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t                 r_state;
  logic [NUM_CORES-1:0]   r_prev_done;
  logic [NUM_CORES-1:0]   r_done_flags;
  logic [DW-1:0]          r_drain_cnt;
  logic [CNT_WIDTH-1:0]   r_cycle_count;
  logic [CNT_WIDTH-1:0]   r_retire_count;
  logic                   r_terminate;
  logic                   r_timed_out;
  logic                   r_running;

  logic [NUM_CORES-1:0]   w_rise;
  logic [NUM_CORES-1:0]   w_flags_next;
  logic                   w_all_done;
  logic                   w_timeout_hit;
  logic [PW-1:0]          w_pop;
  logic [SW-1:0]          w_retire_sum;
  logic [CNT_WIDTH-1:0]   w_retire_next;
  logic [CNT_WIDTH-1:0]   w_cycle_next;

  // A done line only counts on a fresh 0->1 transition, so lines already high at start are ignored
  assign w_rise        = program_done & ~r_prev_done;
  assign w_flags_next  = r_done_flags | w_rise;
  assign w_all_done    = &(w_flags_next | done_mask);
  assign w_timeout_hit = WDOG_EN && (r_cycle_count == TO_LAST);
  assign w_cycle_next  = (r_cycle_count == CNT_MAX) ? r_cycle_count : r_cycle_count + 1'b1;

  // Count retirements this edge across all cores, masked ones included
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_pop = w_pop + PW'(retire_valid[i]);
    end
  end

  // Saturating add: widen, compare against the counter ceiling, clamp
  always_comb begin
    w_retire_sum  = SW'(r_retire_count) + SW'(w_pop);
    w_retire_next = (w_retire_sum > SW'(CNT_MAX)) ? CNT_MAX : w_retire_sum[CNT_WIDTH-1:0];
  end

  // Run-control FSM with registered status outputs; clear overrides every transition
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_prev_done    <= '0;
      r_done_flags   <= '0;
      r_drain_cnt    <= '0;
      r_cycle_count  <= '0;
      r_retire_count <= '0;
      r_terminate    <= 1'b0;
      r_timed_out    <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      r_prev_done <= program_done;
      if (clear) begin
        r_state        <= S_IDLE;
        r_done_flags   <= '0;
        r_drain_cnt    <= '0;
        r_cycle_count  <= '0;
        r_retire_count <= '0;
        r_terminate    <= 1'b0;
        r_timed_out    <= 1'b0;
        r_running      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state        <= S_RUN;
              r_running      <= 1'b1;
              r_done_flags   <= '0;
              r_cycle_count  <= '0;
              r_retire_count <= '0;
            end
          end
          S_RUN: begin
            r_cycle_count  <= w_cycle_next;
            r_retire_count <= w_retire_next;
            r_done_flags   <= w_flags_next;
            if (w_all_done) begin
              r_drain_cnt <= '0;
              if (NO_DRAIN) begin
                r_state     <= S_DONE;
                r_running   <= 1'b0;
                r_terminate <= 1'b1;
              end else begin
                r_state <= S_DRAIN;
              end
            end else if (w_timeout_hit) begin
              r_state     <= S_TIMEOUT;
              r_running   <= 1'b0;
              r_terminate <= 1'b1;
              r_timed_out <= 1'b1;
            end
          end
          S_DRAIN: begin
            r_cycle_count  <= w_cycle_next;
            r_retire_count <= w_retire_next;
            r_drain_cnt    <= r_drain_cnt + 1'b1;
            if (r_drain_cnt == DRAIN_LAST) begin
              r_state     <= S_DONE;
              r_running   <= 1'b0;
              r_terminate <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign terminate    = r_terminate;
  assign timed_out    = r_timed_out;
  assign running      = r_running;
  assign done_flags   = r_done_flags;
  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// tb/tb_pipeline_run_monitor.sv - randomized model-checked bench for pipeline_run_monitor
module tb_pipeline_run_monitor;

  localparam int A_NC    = 4;
  localparam int A_DRAIN = 2;
  localparam int A_TO    = 40;
  localparam int A_CW    = 6;
  localparam int A_MAX   = 63;

  logic clock;
  logic reset_n;

  logic              a_start, a_clear;
  logic [A_NC-1:0]   a_pd, a_mask, a_rv;
  logic              a_term, a_tout, a_run;
  logic [A_NC-1:0]   a_flags;
  logic [A_CW-1:0]   a_cyc, a_ret;

  logic       b_start, b_clear;
  logic [0:0] b_pd, b_mask, b_rv;
  logic       b_term, b_tout, b_run;
  logic [0:0] b_flags;
  logic [7:0] b_cyc, b_ret;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_run_monitor #(
    .NUM_CORES(A_NC), .DRAIN_CYCLES(A_DRAIN), .TIMEOUT_CYCLES(A_TO), .CNT_WIDTH(A_CW)
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(a_start), .clear(a_clear),
    .program_done(a_pd), .done_mask(a_mask), .retire_valid(a_rv),
    .terminate(a_term), .timed_out(a_tout), .running(a_run),
    .done_flags(a_flags), .cycle_count(a_cyc), .retire_count(a_ret)
  );

  pipeline_run_monitor #(
    .NUM_CORES(1), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .CNT_WIDTH(8)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .clear(b_clear),
    .program_done(b_pd), .done_mask(b_mask), .retire_valid(b_rv),
    .terminate(b_term), .timed_out(b_tout), .running(b_run),
    .done_flags(b_flags), .cycle_count(b_cyc), .retire_count(b_ret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks a run by its edge index since start rather than by state
  bit            m_active, m_finished, m_to;
  int            m_k, m_finish_at, m_cycles, m_retires, m_hold;
  bit [A_NC-1:0] m_seen, m_prev;
  bit            quiet;

  task automatic model_reset();
    m_active = 0; m_finished = 0; m_to = 0;
    m_k = 0; m_finish_at = -1; m_cycles = 0; m_retires = 0; m_hold = 0;
    m_seen = '0; m_prev = '0;
  endtask

  task automatic model_step();
    bit [A_NC-1:0] rise;
    int r;
    rise = a_pd & ~m_prev;
    if (a_clear) begin
      m_active = 0; m_finished = 0; m_to = 0;
      m_k = 0; m_finish_at = -1; m_cycles = 0; m_retires = 0; m_seen = '0;
    end else if (!m_active && !m_finished && !m_to) begin
      if (a_start) begin
        m_active = 1; m_k = 0; m_finish_at = -1; m_cycles = 0; m_retires = 0; m_seen = '0;
      end
    end else if (m_active) begin
      m_k++;
      m_cycles = (m_k > A_MAX) ? A_MAX : m_k;
      r = m_retires + $countones(a_rv);
      m_retires = (r > A_MAX) ? A_MAX : r;
      if (m_finish_at < 0) begin
        m_seen |= rise;
        if (&(m_seen | a_mask)) m_finish_at = m_k + A_DRAIN;
        else if (m_k == A_TO) begin
          m_active = 0;
          m_to = 1;
        end
      end
      if (m_finish_at >= 0 && m_k == m_finish_at) begin
        m_active = 0;
        m_finished = 1;
      end
    end
    m_prev = a_pd;
    m_hold = (m_finished || m_to) ? m_hold + 1 : 0;
  endtask

  task automatic compare_a(input string pfx);
    check({pfx, "running"},   64'(a_run),   64'(m_active));
    check({pfx, "terminate"}, 64'(a_term),  64'(m_finished | m_to));
    check({pfx, "timed_out"}, 64'(a_tout),  64'(m_to));
    check({pfx, "flags"},     64'(a_flags), 64'(m_seen));
    check({pfx, "cycles"},    64'(a_cyc),   64'(m_cycles));
    check({pfx, "retires"},   64'(a_ret),   64'(m_retires));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_start = 0; a_clear = 0; a_pd = '0; a_mask = '0; a_rv = '0;
    b_start = 0; b_clear = 0; b_pd = '0; b_mask = '0; b_rv = '0;
    quiet = 0;
    model_reset();
    tick();
    compare_a("reset_");
    check("b_reset_term", 64'(b_term), 64'd0);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_a("async_rst_");
        tick();
        reset_n = 1'b1;
      end
      if (!m_active && !m_finished && !m_to) begin
        quiet  = ($urandom_range(0, 3) == 0);
        a_mask = ($urandom_range(0, 7) == 0) ? '1 : A_NC'($urandom);
        if (quiet) a_mask = '0;
        a_start = ($urandom_range(0, 2) == 0);
      end else begin
        a_start = ($urandom_range(0, 7) == 0);
      end
      a_clear = (m_hold >= 3) ? 1'b1 : ($urandom_range(0, 79) == 0);
      if (!quiet) begin
        for (int i = 0; i < A_NC; i++) begin
          if ($urandom_range(0, 5) == 0) a_pd[i] = ~a_pd[i];
        end
      end
      a_rv = A_NC'($urandom);
      tick();
      model_step();
      compare_a("a_");
    end

    // Zero-drain instance: pre-high done ignored, terminate on the detection edge
    b_clear = 1; tick(); b_clear = 0;
    b_pd = 1'b1; b_start = 1; tick(); b_start = 0;
    check("b_start_run", 64'(b_run), 64'd1);
    repeat (4) tick();
    check("b_prehigh_flags", 64'(b_flags), 64'd0);
    check("b_prehigh_run", 64'(b_run), 64'd1);
    b_pd = 1'b0; tick();
    b_pd = 1'b1; tick();
    check("b_nodrain_term", 64'(b_term), 64'd1);
    check("b_nodrain_run", 64'(b_run), 64'd0);
    check("b_nodrain_cyc", 64'(b_cyc), 64'd6);
    check("b_nodrain_flags", 64'(b_flags), 64'd1);
    check("b_nodrain_tout", 64'(b_tout), 64'd0);
    b_start = 1; tick();
    check("b_done_ignores_start", 64'(b_term), 64'd1);
    b_clear = 1; tick(); b_clear = 0; b_start = 0;
    check("b_clear_start_term", 64'(b_term), 64'd0);
    check("b_clear_start_run", 64'(b_run), 64'd0);
    check("b_clear_cyc", 64'(b_cyc), 64'd0);
    b_pd = 1'b0; b_rv = 1'b1; b_start = 1; tick(); b_start = 0;
    repeat (300) tick();
    check("b_nowdog_run", 64'(b_run), 64'd1);
    check("b_nowdog_tout", 64'(b_tout), 64'd0);
    check("b_cyc_sat", 64'(b_cyc), 64'd255);
    check("b_ret_sat", 64'(b_ret), 64'd255);
    reset_n = 1'b0;
    #1;
    check("b_midrun_rst_run", 64'(b_run), 64'd0);
    check("b_midrun_rst_cyc", 64'(b_cyc), 64'd0);
    check("b_midrun_rst_term", 64'(b_term), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
